pll_phase_ctrl: RTL and testbench

Single-clock supervisor and dynamic phase-shift sequencer for the ECP5 EHXPLLL that feeds the USB clock domains. It runs on the 50 MHz PLL reference clock and filters the asynchronous PLL `LOCK` output into a clean `pll_ready`. It accepts phase-shift requests over a valid/ready handshake and drives the PLL `PHASESEL`/`PHASEDIR`/`PHASESTEP`/`PHASELOADREG` pins with the required setup and pulse spacing. Downstream reset generators gate on `pll_ready`.

---
 rtl/pll_ctrl_pkg.sv | 27 ++
 rtl/pll_lock_filter.sv | 38 +++
 rtl/pll_phase_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the ECP5 PLL supervisor / phase-shift sequencer.
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK,
      ST_IDLE,
      ST_SETUP,
      ST_STEP_LO,
      ST_STEP_HI,
      ST_LOAD,
      ST_LOAD_GAP,
      ST_SETTLE
   } pll_state_e;

   localparam logic [1:0] SEL_CLKOS  = 2'd0;
   localparam logic [1:0] SEL_CLKOS2 = 2'd1;
   localparam logic [1:0] SEL_CLKOS3 = 2'd2;
   localparam logic [1:0] SEL_CLKOP  = 2'd3;

   localparam logic STEP_IDLE = 1'b1;
   localparam logic LOAD_IDLE = 1'b1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Synchronizes the raw PLL LOCK and qualifies it with a saturating run-length counter.
module pll_lock_filter #(
   parameter int LOCK_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic pll_locked,
   output logic lk_s,
   output logic lock_stable
);

   localparam int CW = $clog2(LOCK_CYCLES + 1);

   logic          sync_p0;
   logic          sync_p1;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_p0 <= pll_locked;
         sync_p1 <= sync_p0;
         if (!sync_p1)
            cnt <= '0;
         else if (cnt != CW'(LOCK_CYCLES))
            cnt <= cnt + CW'(1);
      end
   end

   assign lk_s = sync_p1;
   // Stable already in the cycle that completes the run, so the FSM leaves WAIT_LOCK on that edge.
   assign lock_stable = sync_p1 &&
                        ((cnt == CW'(LOCK_CYCLES - 1)) || (cnt == CW'(LOCK_CYCLES)));

endmodule

// File: rtl/pll_phase_ctrl.sv
// EHXPLLL supervisor: filtered lock indication plus PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG sequencing.
module pll_phase_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int LOCK_CYCLES   = 50000,
   parameter int SETUP_CYCLES  = 4,
   parameter int PULSE_CYCLES  = 4,
   parameter int GAP_CYCLES    = 4,
   parameter int SETTLE_CYCLES = 64,
   parameter int STEP_W        = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pll_locked,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_sel,
   input  logic              req_dir,
   input  logic [STEP_W-1:0] req_steps,
   input  logic              req_load,
   output logic              pll_ready,
   output logic              busy,
   output logic              done,
   output logic              lock_lost,
   input  logic              lock_lost_clr,
   output logic [1:0]        phasesel,
   output logic              phasedir,
   output logic              phasestep,
   output logic              phaseloadreg
);

   localparam int TMAX = max_int(max_int(SETUP_CYCLES, PULSE_CYCLES),
                                 max_int(GAP_CYCLES, SETTLE_CYCLES));
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TW-1:0] T_SETUP  = TW'(SETUP_CYCLES - 1);
   localparam logic [TW-1:0] T_PULSE  = TW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] T_GAP    = TW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE_CYCLES - 1);

   pll_state_e        state;
   pll_state_e        state_nx;
   logic [TW-1:0]     timer;
   logic [TW-1:0]     timer_nx;
   logic [STEP_W-1:0] step_cnt;
   logic              load_flag;
   logic              lk_s;
   logic              lock_stable;
   logic              lock_drop;
   logic              accept;
   logic              step_dec;
   logic              done_c;
   pll_state_e        tail_state;
   logic [TW-1:0]     tail_timer;

   pll_lock_filter #(
      .LOCK_CYCLES (LOCK_CYCLES)
   ) u_lock_filter (
      .clk         (clk),
      .reset       (reset),
      .pll_locked  (pll_locked),
      .lk_s        (lk_s),
      .lock_stable (lock_stable)
   );

   assign lock_drop = (state != ST_WAIT_LOCK) && !lk_s;

   // Where the sequence goes once no step pulses remain.
   always_comb begin
      tail_state = ST_SETTLE;
      tail_timer = T_SETTLE;
      if (load_flag) begin
         tail_state = ST_LOAD;
         tail_timer = T_PULSE;
      end
   end

   always_comb begin
      state_nx = state;
      timer_nx = (timer != '0) ? (timer - TW'(1)) : timer;
      accept   = 1'b0;
      step_dec = 1'b0;
      done_c   = 1'b0;
      case (state)
         ST_WAIT_LOCK: begin
            if (lock_stable)
               state_nx = ST_IDLE;
         end
         ST_IDLE: begin
            if (req_valid && lk_s) begin
               accept   = 1'b1;
               state_nx = ST_SETUP;
               timer_nx = T_SETUP;
            end
         end
         ST_SETUP: begin
            if (timer == '0) begin
               if (step_cnt != '0) begin
                  state_nx = ST_STEP_LO;
                  timer_nx = T_PULSE;
               end else begin
                  state_nx = tail_state;
                  timer_nx = tail_timer;
               end
            end
         end
         ST_STEP_LO: begin
            if (timer == '0) begin
               step_dec = 1'b1;
               state_nx = ST_STEP_HI;
               timer_nx = T_GAP;
            end
         end
         ST_STEP_HI: begin
            if (timer == '0) begin
               if (step_cnt != '0) begin
                  state_nx = ST_STEP_LO;
                  timer_nx = T_PULSE;
               end else begin
                  state_nx = tail_state;
                  timer_nx = tail_timer;
               end
            end
         end
         ST_LOAD: begin
            if (timer == '0) begin
               state_nx = ST_LOAD_GAP;
               timer_nx = T_GAP;
            end
         end
         ST_LOAD_GAP: begin
            if (timer == '0) begin
               state_nx = ST_SETTLE;
               timer_nx = T_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (timer == '0) begin
               state_nx = ST_IDLE;
               done_c   = 1'b1;
            end
         end
         default: state_nx = ST_WAIT_LOCK;
      endcase
      // Losing lock aborts everything; IDLE cannot accept then since req_ready already follows lk_s.
      if (lock_drop) begin
         state_nx = ST_WAIT_LOCK;
         accept   = 1'b0;
         done_c   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_WAIT_LOCK;
         timer        <= '0;
         step_cnt     <= '0;
         load_flag    <= 1'b0;
         phasesel     <= SEL_CLKOS;
         phasedir     <= 1'b1;
         phasestep    <= STEP_IDLE;
         phaseloadreg <= LOAD_IDLE;
         lock_lost    <= 1'b0;
      end else begin
         state <= state_nx;
         timer <= timer_nx;
         if (accept) begin
            step_cnt  <= req_steps;
            load_flag <= req_load;
            phasesel  <= req_sel;
            phasedir  <= req_dir;
         end else if (step_dec) begin
            step_cnt <= step_cnt - STEP_W'(1);
         end
         // Pins follow the next state so they release on the same edge a lock loss aborts.
         phasestep    <= (state_nx == ST_STEP_LO) ? ~STEP_IDLE : STEP_IDLE;
         phaseloadreg <= (state_nx == ST_LOAD)    ? ~LOAD_IDLE : LOAD_IDLE;
         if (lock_drop)
            lock_lost <= 1'b1;
         else if (lock_lost_clr)
            lock_lost <= 1'b0;
      end
   end

   assign req_ready = (state == ST_IDLE) && lk_s;
   assign pll_ready = (state != ST_WAIT_LOCK);
   assign busy      = (state != ST_WAIT_LOCK) && (state != ST_IDLE);
   assign done      = done_c;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl with short timing parameters.
module tb_pll_phase_ctrl;
   import pll_ctrl_pkg::*;

   localparam int MAXC = 1300;

   logic       clk = 1'b0;
   logic       reset;
   logic       pll_locked;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_sel;
   logic       req_dir;
   logic [7:0] req_steps;
   logic       req_load;
   logic       pll_ready;
   logic       busy;
   logic       done;
   logic       lock_lost;
   logic       lock_lost_clr;
   logic [1:0] phasesel;
   logic       phasedir;
   logic       phasestep;
   logic       phaseloadreg;

   int n_cmp = 0;
   int n_bad = 0;

   logic busy_t [1:MAXC];
   logic step_t [1:MAXC];
   logic load_t [1:MAXC];
   logic done_t [1:MAXC];
   logic rdy_t  [1:MAXC];

   pll_phase_ctrl #(
      .LOCK_CYCLES   (16),
      .SETUP_CYCLES  (2),
      .PULSE_CYCLES  (3),
      .GAP_CYCLES    (2),
      .SETTLE_CYCLES (5),
      .STEP_W        (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .pll_locked    (pll_locked),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_sel       (req_sel),
      .req_dir       (req_dir),
      .req_steps     (req_steps),
      .req_load      (req_load),
      .pll_ready     (pll_ready),
      .busy          (busy),
      .done          (done),
      .lock_lost     (lock_lost),
      .lock_lost_clr (lock_lost_clr),
      .phasesel      (phasesel),
      .phasedir      (phasedir),
      .phasestep     (phasestep),
      .phaseloadreg  (phaseloadreg)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycles from now until pll_ready is seen high (0 if never); counts stray activity meanwhile.
   task automatic wait_ready(output int lat, output int bad);
      lat = 0;
      bad = 0;
      for (int i = 1; i <= 60; i++) begin
         if (lat == 0) begin
            tick();
            if (pll_ready)
               lat = i;
            else if (req_ready || busy || done || !phasestep || !phaseloadreg)
               bad++;
         end
      end
   endtask

   task automatic run_req(input logic [1:0] sel, input logic dir, input logic [7:0] steps,
                          input logic load, input int ncyc, input int drop_at);
      req_sel   = sel;
      req_dir   = dir;
      req_steps = steps;
      req_load  = load;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int k = 1; k <= ncyc; k++) begin
         busy_t[k] = busy;
         step_t[k] = phasestep;
         load_t[k] = phaseloadreg;
         done_t[k] = done;
         rdy_t[k]  = req_ready;
         if (k == drop_at)
            pll_locked = 1'b0;
         tick();
      end
   endtask

   // Cycle 1 is the first busy cycle: SETUP 2, then 3 low / 2 high per step, load alike, SETTLE 5.
   task automatic check_seq(input string tag, input int ncyc, input int steps, input int load,
                            input int exp_busy);
      int   blen  = 0;
      int   bfirst = 0;
      int   dcnt  = 0;
      int   didx  = 0;
      int   serr  = 0;
      int   lerr  = 0;
      int   ls;
      logic exp_s;
      logic exp_l;
      ls = 3 + 5 * steps;
      for (int k = 1; k <= ncyc; k++) begin
         if (busy_t[k]) begin
            blen++;
            if (bfirst == 0) bfirst = k;
         end
         if (done_t[k]) begin
            dcnt++;
            didx = k;
         end
         exp_s = !(k >= 3 && k < ls && ((k - 3) % 5) < 3);
         exp_l = !(load != 0 && k >= ls && k < ls + 3);
         if (step_t[k] !== exp_s) serr++;
         if (load_t[k] !== exp_l) lerr++;
      end
      chk({tag, "_busy_len"},   blen,   exp_busy);
      chk({tag, "_busy_first"}, bfirst, 1);
      chk({tag, "_done_cnt"},   dcnt,   1);
      chk({tag, "_done_idx"},   didx,   exp_busy);
      chk({tag, "_step_err"},   serr,   0);
      chk({tag, "_load_err"},   lerr,   0);
      chk({tag, "_rdy_last"},   int'(rdy_t[exp_busy]),     0);
      chk({tag, "_rdy_after"},  int'(rdy_t[exp_busy + 1]), 1);
   endtask

   initial begin
      int lat;
      int bad;
      reset         = 1'b1;
      pll_locked    = 1'b0;
      req_valid     = 1'b0;
      req_sel       = 2'd0;
      req_dir       = 1'b0;
      req_steps     = 8'd0;
      req_load      = 1'b0;
      lock_lost_clr = 1'b0;
      repeat (3) tick();

      chk("rst_pll_ready", int'(pll_ready), 0);
      chk("rst_busy",      int'(busy), 0);
      chk("rst_done",      int'(done), 0);
      chk("rst_lock_lost", int'(lock_lost), 0);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_step",      int'(phasestep), 1);
      chk("rst_load",      int'(phaseloadreg), 1);
      chk("rst_dir",       int'(phasedir), 1);
      chk("rst_sel",       int'(phasesel), 0);

      // First lock: 2 sync cycles + 16 stable cycles.
      reset      = 1'b0;
      pll_locked = 1'b1;
      wait_ready(lat, bad);
      chk("lock_lat",     lat, 18);
      chk("prelock_quiet", bad, 0);
      chk("lock_lost_init", int'(lock_lost), 0);
      chk("req_ready_idle", int'(req_ready), 1);

      // Lock loss while ready: falls 3 cycles after the drop.
      pll_locked = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         if (lat == 0) begin
            tick();
            if (!pll_ready) lat = i;
         end
      end
      chk("unlock_lat",   lat, 3);
      chk("idle_lost",    int'(lock_lost), 1);
      tick();
      lock_lost_clr = 1'b1;
      tick();
      lock_lost_clr = 1'b0;
      chk("clr_in_wait",  int'(lock_lost), 0);

      // Glitch restarts the stable counter.
      pll_locked = 1'b1;
      repeat (10) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      chk("glitch_no_ready", int'(pll_ready), 0);
      wait_ready(lat, bad);
      chk("glitch_lat",   lat, 18);
      chk("glitch_quiet", bad, 0);

      // Three steps, no load: busy 2 + 3*5 + 5 = 22.
      run_req(SEL_CLKOP, 1'b0, 8'd3, 1'b0, 30, 0);
      check_seq("s3", 30, 3, 0, 22);
      chk("s3_sel", int'(phasesel), 3);
      chk("s3_dir", int'(phasedir), 0);

      // Load only: busy 2 + 5 + 5 = 12.
      run_req(SEL_CLKOS2, 1'b1, 8'd0, 1'b1, 20, 0);
      check_seq("ld", 20, 0, 1, 12);
      chk("ld_sel", int'(phasesel), 1);
      chk("ld_dir", int'(phasedir), 1);

      // Maximum step count with load: 2 + 255*5 + 5 + 5 = 1287.
      run_req(SEL_CLKOS3, 1'b1, 8'd255, 1'b1, 1295, 0);
      check_seq("max", 1295, 255, 1, 1287);

      // Drop lock in cycle 8 (second STEP_LO); pins release at cycle 11.
      run_req(SEL_CLKOS2, 1'b1, 8'd3, 1'b0, 14, 8);
      chk("drop_step_c10", int'(step_t[10]), 0);
      chk("drop_step_c11", int'(step_t[11]), 1);
      chk("drop_busy_c10", int'(busy_t[10]), 1);
      chk("drop_busy_c11", int'(busy_t[11]), 0);
      bad = 0;
      for (int k = 1; k <= 14; k++)
         if (done_t[k]) bad++;
      chk("drop_no_done", bad, 0);
      chk("drop_lost",    int'(lock_lost), 1);
      chk("drop_rdy",     int'(req_ready), 0);
      pll_locked = 1'b1;
      wait_ready(lat, bad);
      chk("relock_lat",   lat, 18);
      chk("relock_quiet", bad, 0);
      chk("relock_lost",  int'(lock_lost), 1);

      // Clear coinciding with a new loss keeps the flag; a lone clear drops it.
      pll_locked = 1'b0;
      tick();
      tick();
      lock_lost_clr = 1'b1;
      tick();
      lock_lost_clr = 1'b0;
      chk("clr_vs_set",    int'(lock_lost), 1);
      chk("clr_vs_set_rdy", int'(pll_ready), 0);
      tick();
      lock_lost_clr = 1'b1;
      tick();
      lock_lost_clr = 1'b0;
      chk("clr_lone", int'(lock_lost), 0);
      tick();
      chk("clr_hold", int'(lock_lost), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
